// File: rtl/seg_display_encoder_pkg.sv
// Shared glyph constants, FSM state encoding and the double-dabble nibble adjust.
// Combinational definitions only; no latency.
// No flow control here.
// Glyph bit order is {a,b,c,d,e,f,g} with a in the MSB, active-high.
package seg_pkg;

    localparam logic [6:0] SEG_0     = 7'b1111110;
    localparam logic [6:0] SEG_1     = 7'b0110000;
    localparam logic [6:0] SEG_2     = 7'b1101101;
    localparam logic [6:0] SEG_3     = 7'b1111001;
    localparam logic [6:0] SEG_4     = 7'b0110011;
    localparam logic [6:0] SEG_5     = 7'b1011011;
    localparam logic [6:0] SEG_6     = 7'b1011111;
    localparam logic [6:0] SEG_7     = 7'b1110000;
    localparam logic [6:0] SEG_8     = 7'b1111111;
    localparam logic [6:0] SEG_9     = 7'b1111011;
    localparam logic [6:0] SEG_A     = 7'b1110111;
    localparam logic [6:0] SEG_B     = 7'b0011111;
    localparam logic [6:0] SEG_C     = 7'b1001110;
    localparam logic [6:0] SEG_D     = 7'b0111101;
    localparam logic [6:0] SEG_E     = 7'b1001111;
    localparam logic [6:0] SEG_F     = 7'b1000111;
    localparam logic [6:0] SEG_MINUS = 7'b0000001;
    localparam logic [6:0] SEG_PLUS  = 7'b0000000;
    localparam logic [6:0] SEG_BLANK = 7'b0000000;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        CONV = 2'd1,
        LOAD = 2'd2
    } seg_state_t;

    // Add 3 to every BCD nibble that is 5 or more, ahead of the left shift.
    function automatic logic [11:0] dd_adjust(input logic [11:0] b);
        logic [11:0] r;
        r = b;
        for (int i = 0; i < 3; i++) begin
            if (b[4*i +: 4] >= 4'd5) begin
                r[4*i +: 4] = b[4*i +: 4] + 4'd3;
            end
        end
        return r;
    endfunction

endpackage

// File: rtl/seg_display_encoder_if.sv
// Handshake and display bus between the requester and seg_display_encoder.
// No latency; wires only.
// start is honoured only while busy is low; there is no queueing.
// Signals: start/value(/hex_mode) toward the encoder; busy/done/seg_* back.
// hex_mode exists only when SEG_HEX_EN is defined.
interface seg_display_encoder_if;
    logic       start;
    logic [7:0] value;
`ifdef SEG_HEX_EN
    logic       hex_mode;
`endif
    logic       busy;
    logic       done;
    logic [6:0] seg_hund;
    logic [6:0] seg_ten;
    logic [6:0] seg_one;
    logic [6:0] seg_neg;

`ifdef SEG_HEX_EN
    modport master (output start, value, hex_mode,
                    input  busy, done, seg_hund, seg_ten, seg_one, seg_neg);
    modport slave  (input  start, value, hex_mode,
                    output busy, done, seg_hund, seg_ten, seg_one, seg_neg);
`else
    modport master (output start, value,
                    input  busy, done, seg_hund, seg_ten, seg_one, seg_neg);
    modport slave  (input  start, value,
                    output busy, done, seg_hund, seg_ten, seg_one, seg_neg);
`endif
endinterface

// File: rtl/seg_display_encoder_glyph.sv
// Nibble to seven-segment glyph lookup (module seg_glyph).
// Purely combinational, zero cycles.
// No flow control.
// Ports: nib (4-bit digit in), glyph (7-bit {a..g} out).
module seg_glyph
    import seg_pkg::*;
(
    input  logic [3:0] nib,
    output logic [6:0] glyph
);
    always_comb begin
        glyph = SEG_0;
        case (nib)
            4'h0: glyph = SEG_0;
            4'h1: glyph = SEG_1;
            4'h2: glyph = SEG_2;
            4'h3: glyph = SEG_3;
            4'h4: glyph = SEG_4;
            4'h5: glyph = SEG_5;
            4'h6: glyph = SEG_6;
            4'h7: glyph = SEG_7;
            4'h8: glyph = SEG_8;
            4'h9: glyph = SEG_9;
            4'hA: glyph = SEG_A;
            4'hB: glyph = SEG_B;
            4'hC: glyph = SEG_C;
            4'hD: glyph = SEG_D;
            4'hE: glyph = SEG_E;
            4'hF: glyph = SEG_F;
            default: glyph = SEG_0;
        endcase
    end
endmodule

// File: rtl/seg_display_encoder.sv
// Signed 8-bit value to sign + three decimal seven-segment glyphs via sequential double-dabble.
// Latency 9 cycles from accepted start to done (1 cycle in hex mode when SEG_HEX_EN is defined).
// start ignored while busy; done is a one-cycle pulse; outputs hold until the next result.
// Ports: clock, rst (sync active-low), bus (slave modport: start/value[/hex_mode] in,
// busy/done/seg_hund/seg_ten/seg_one/seg_neg out).
module seg_display_encoder
    import seg_pkg::*;
#(
    parameter int CONV_CYCLES = 8
) (
    input  logic                  clock,
    input  logic                  rst,
    seg_display_encoder_if.slave  bus
);
    localparam int CW = $clog2(CONV_CYCLES);
    localparam logic [CW-1:0] LAST = CW'(CONV_CYCLES - 1);

    seg_state_t    state_q, state_d;
    logic [CW-1:0] count_q, count_d;
    logic [7:0]    mag_q, mag_d;
    logic [11:0]   bcd_q, bcd_d;
    logic          neg_q, neg_d;
    logic          done_q, done_d;
    logic [6:0]    hund_q, hund_d, ten_q, ten_d, one_q, one_d, sign_q, sign_d;
    logic [11:0]   bcd_adj;
    logic [3:0]    nib_h, nib_t, nib_o;
    logic [6:0]    g_h, g_t, g_o;
`ifdef SEG_HEX_EN
    logic          hex_q, hex_d;
`endif

    seg_glyph u_glyph_hund (.nib(nib_h), .glyph(g_h));
    seg_glyph u_glyph_ten  (.nib(nib_t), .glyph(g_t));
    seg_glyph u_glyph_one  (.nib(nib_o), .glyph(g_o));

    assign bcd_adj = dd_adjust(bcd_q);

    // Hex results bypass the BCD register and show the raw operand nibbles.
    always_comb begin
        nib_h = bcd_q[11:8];
        nib_t = bcd_q[7:4];
        nib_o = bcd_q[3:0];
`ifdef SEG_HEX_EN
        if (hex_q) begin
            nib_t = mag_q[7:4];
            nib_o = mag_q[3:0];
        end
`endif
    end

    always_ff @(posedge clock) begin
        if (!rst) begin
            state_q <= IDLE;
        end else begin
            state_q <= state_d;
        end
    end

    always_ff @(posedge clock) begin
        if (!rst) begin
            count_q <= '0;
            mag_q   <= '0;
            bcd_q   <= '0;
            neg_q   <= 1'b0;
            done_q  <= 1'b0;
            hund_q  <= SEG_0;
            ten_q   <= SEG_0;
            one_q   <= SEG_0;
            sign_q  <= SEG_PLUS;
`ifdef SEG_HEX_EN
            hex_q   <= 1'b0;
`endif
        end else begin
            count_q <= count_d;
            mag_q   <= mag_d;
            bcd_q   <= bcd_d;
            neg_q   <= neg_d;
            done_q  <= done_d;
            hund_q  <= hund_d;
            ten_q   <= ten_d;
            one_q   <= one_d;
            sign_q  <= sign_d;
`ifdef SEG_HEX_EN
            hex_q   <= hex_d;
`endif
        end
    end

    always_comb begin
        state_d = state_q;
        count_d = count_q;
        mag_d   = mag_q;
        bcd_d   = bcd_q;
        neg_d   = neg_q;
        done_d  = 1'b0;
        hund_d  = hund_q;
        ten_d   = ten_q;
        one_d   = one_q;
        sign_d  = sign_q;
`ifdef SEG_HEX_EN
        hex_d   = hex_q;
`endif
        case (state_q)
            IDLE: begin
                if (bus.start) begin
                    // Magnitude as unsigned: -128 negates to 8'h80 = 128.
                    neg_d   = bus.value[7];
                    mag_d   = bus.value[7] ? (~bus.value + 8'd1) : bus.value;
                    bcd_d   = 12'h000;
                    count_d = '0;
                    state_d = CONV;
`ifdef SEG_HEX_EN
                    hex_d = 1'b0;
                    if (bus.hex_mode) begin
                        hex_d   = 1'b1;
                        neg_d   = 1'b0;
                        mag_d   = bus.value;
                        state_d = LOAD;
                    end
`endif
                end
            end
            CONV: begin
                bcd_d   = {bcd_adj[10:0], mag_q[7]};
                mag_d   = {mag_q[6:0], 1'b0};
                count_d = count_q + 1'b1;
                if (count_q == LAST) begin
                    state_d = LOAD;
                end
            end
            LOAD: begin
                hund_d  = g_h;
`ifdef SEG_HEX_EN
                if (hex_q) begin
                    hund_d = SEG_BLANK;
                end
`endif
                ten_d   = g_t;
                one_d   = g_o;
                sign_d  = neg_q ? SEG_MINUS : SEG_PLUS;
                done_d  = 1'b1;
                state_d = IDLE;
            end
            default: state_d = IDLE;
        endcase
    end

    assign bus.busy     = (state_q != IDLE);
    assign bus.done     = done_q;
    assign bus.seg_hund = hund_q;
    assign bus.seg_ten  = ten_q;
    assign bus.seg_one  = one_q;
    assign bus.seg_neg  = sign_q;

endmodule

// File: doc/seg_display_encoder.md
# seg_display_encoder

Converts an 8-bit two's-complement value from the tiny_risc_v memory read port into seven-segment drive for a sign digit and three decimal digits. Sits between the core's `q` output and the board display. Its segment patterns are exactly the ones the bench's seven-segment checker decodes. Conversion is a sequential double-dabble over 8 cycles behind a start/busy/done handshake.

## Interface
Parameters:
- `CONV_CYCLES`, 8: double-dabble iterations; equals value width and is not overridden.

Ports:
- `clock`  in  1  rising-edge clock
- `rst`  in  1  synchronous reset, active-low
- `start`  in  1  request conversion of `value`; accepted only when `busy`=0
- `value`  in  8  signed operand, sampled on the accepting edge
- `hex_mode`  in  1  present only with `SEG_HEX_EN`; sampled with `start`
- `busy`  out  1  conversion in progress
- `done`  out  1  one-cycle pulse; segment outputs updated on the same edge
- `seg_hund`, `seg_ten`, `seg_one`  out  7 each  digit glyphs, bit order {a,b,c,d,e,f,g}, MSB=a, active-high
- `seg_neg`  out  7  sign glyph: 7'b0000001 for minus, 7'b0000000 for plus

## Operation
- States: IDLE, CONV, LOAD.
- IDLE: `start`=1 → capture `neg`=`value[7]` and `mag` = `neg` ? −`value` : `value`, as 8-bit unsigned. −128 yields 128, so no overflow. Clear BCD register to 12'h000. Go to CONV, count=0.
- CONV: each cycle, add 3 to every BCD nibble ≥5, then shift {bcd,mag} left 1. Count increments. After the 8th shift, go to LOAD.
- LOAD: register glyphs for hundreds, tens and ones, plus `seg_neg`. Pulse `done`. Go to IDLE.
- Glyphs for 0–F: 1111110, 0110000, 1101101, 1111001, 0110011, 1011011, 1011111, 1110000, 1111111, 1111011, 1110111, 0011111, 1001110, 0111101, 1001111, 1000111.
- Leading zeros are displayed, not blanked.
- `start` while `busy`=1 is ignored; no queueing.
- Segment outputs hold the last result until the next LOAD.

## Timing
- Reset (`rst`=0 at an edge): state IDLE, `busy`=0, `done`=0, all three digits 7'b1111110, `seg_neg`=7'b0000000.
- Reset mid-conversion aborts. No `done` is produced, and outputs return to their reset values.
- If `start` is accepted at edge N:
  - `busy` goes to 1 at N.
  - CONV runs over edges N+1..N+8.
  - LOAD at N+9: outputs update, `done`=1 for one cycle, `busy`=0.
- Latency is 9 cycles from start to done.
- `start` held high during the `done` cycle is accepted, which gives back-to-back conversions every 10 cycles.
- `busy` and `done` are never both 1.

## Configuration
- `SEG_HEX_EN` defined: adds the `hex_mode` port.
  - `hex_mode`=1 with `start` skips CONV and goes directly to LOAD, with `done` at edge N+1.
  - `seg_hund`=7'b0000000 (blank).
  - `seg_ten` shows glyph of `value[7:4]`, `seg_one` shows glyph of `value[3:0]`.
  - `seg_neg` shows plus.
  - `hex_mode`=0 behaves as the decimal path.
- `SEG_HEX_EN` undefined: no `hex_mode` port; decimal only.

## Structure
- Package `seg_pkg`:
  - 16 glyph constants `SEG_0`..`SEG_F`, plus `SEG_MINUS`, `SEG_PLUS` and `SEG_BLANK`.
  - State enum `seg_state_t`.
  - The same constants feed the bench checker.
- Sub-module `seg_glyph`: combinational 4-bit nibble → 7-bit glyph. Instantiated three times.

## Test plan
- Reset: hold `rst`=0 for 2 cycles → digits 1111110 ×3, `seg_neg`=0000000, `busy`=0, `done`=0.
- `value`=8'd37, `start` pulse → `done` exactly 9 cycles later; hund 1111110, ten 1111001, one 1110000, neg 0000000.
- `value`=8'h80 (−128) → hund 0110000, ten 1101101, one 1111111, neg 0000001.
- `value`=8'hFF (−1) → 1111110, 1111110, 0110000, neg 0000001. Then `start` held continuously → second `done` 10 cycles after the first.
- `start` with 8'd99, then `start` with 8'd5 at cycle 3 → only 99 result appears. A new run with `rst`=0 at cycle 4 → reset values, no `done`.
- With `SEG_HEX_EN`, `hex_mode`=1, `value`=8'hAF → `done` next cycle; hund 0000000, ten 1110111, one 1000111, neg 0000000.
